// File: rtl/f2h_pkg.sv
// f2h_pkg: shared widths and word type for the FPGA-to-HPS result FIFO
package f2h_pkg;
  localparam int F2H_WIDTH = 32;
  localparam int F2H_DEPTH = 16;
  localparam int F2H_PTR_W = $clog2(F2H_DEPTH);
  localparam int F2H_CNT_W = F2H_PTR_W + 1;
  typedef logic [F2H_WIDTH-1:0] f2h_word_t;
endpackage

// File: rtl/f2h_fifo_mem.sv
// f2h_fifo_mem: register array, one synchronous write port, one asynchronous read port
module f2h_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // store accepted words; contents need no reset since they are masked while empty
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/f2h_result_fifo.sv
// f2h_result_fifo: show-ahead result FIFO feeding the HPS PIO read port, with sticky error flags
module f2h_result_fifo
  import f2h_pkg::*;
#(
  parameter int WIDTH = F2H_WIDTH,
  parameter int DEPTH = F2H_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d, push, pop;
  logic [WIDTH-1:0] head;
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(DEPTH);
  assign wr_ready  = !full;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign rd_data   = empty ? '0 : head;
  f2h_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push && !flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );
  // handshake and next state; flush overrides any push or pop in the same cycle
  always_comb begin
    push     = wr_valid && !full;
    pop      = rd_en && !empty;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
    ovf_d    = !flush && (ovf_q || (wr_valid && full));
    unf_d    = !flush && (unf_q || (rd_en && empty));
  end
  // state registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
endmodule

// File: tb/tb_f2h_result_fifo.sv
// tb_f2h_result_fifo: directed table-driven checks of the show-ahead result FIFO
module tb_f2h_result_fifo;
  import f2h_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0, wr_valid = 0, rd_en = 0;
  f2h_word_t wr_data = '0, rd_data;
  logic wr_ready, empty, full, overflow, underflow;
  logic [4:0] count;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  f2h_result_fifo dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );
  typedef struct {
    logic fl, wv;
    logic [31:0] wd;
    logic re;
    int ec;
    logic ee, ef, eo, eu;
    logic [31:0] er;
  } vec_t;
  vec_t tv [9];
  logic [31:0] seq [48];
  task automatic expect_st(input string nm, input int ec, input logic ee, ef, eo, eu, input logic [31:0] er);
    logic [41:0] act, exp;
    act = {count, empty, full, wr_ready, overflow, underflow, rd_data};
    exp = {5'(ec), ee, ef, !ef, eo, eu, er};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {count,empty,full,wr_ready,ovf,unf,rd_data}=%h required %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic fl, wv, input logic [31:0] wd, input logic re);
    @(negedge clk);
    flush = fl; wr_valid = wv; wr_data = wd; rd_en = re;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    @(negedge clk);
    flush = 0; wr_valid = 0; rd_en = 0;
  endtask
  initial begin
    tv[0] = '{0, 1, 32'h11111111, 0, 1, 0, 0, 0, 0, 32'h11111111};
    tv[1] = '{0, 1, 32'h22222222, 0, 2, 0, 0, 0, 0, 32'h11111111};
    tv[2] = '{0, 1, 32'h33333333, 0, 3, 0, 0, 0, 0, 32'h11111111};
    tv[3] = '{0, 0, 32'h0,        1, 2, 0, 0, 0, 0, 32'h22222222};
    tv[4] = '{0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 32'h33333333};
    tv[5] = '{0, 0, 32'h0,        1, 0, 1, 0, 0, 0, 32'h0};
    tv[6] = '{0, 1, 32'hA5A5A5A5, 1, 1, 0, 0, 0, 1, 32'hA5A5A5A5};
    tv[7] = '{0, 0, 32'h0,        0, 1, 0, 0, 0, 1, 32'hA5A5A5A5};
    tv[8] = '{1, 1, 32'h77777777, 1, 0, 1, 0, 0, 0, 32'h0};
    repeat (2) @(posedge clk);
    #1 expect_st("reset", 0, 1, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1 expect_st("idle", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(tv[i].fl, tv[i].wv, tv[i].wd, tv[i].re);
      expect_st($sformatf("vec%0d", i), tv[i].ec, tv[i].ee, tv[i].ef, tv[i].eo, tv[i].eu, tv[i].er);
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 32'(i), 0);
      expect_st($sformatf("fill%0d", i), i + 1, 0, i == 15, 0, 0, 0);
    end
    step(0, 1, 32'hDEAD, 0);
    expect_st("push_full", 16, 0, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1);
      expect_st($sformatf("drain%0d", i), 15 - i, i == 15, 0, 1, 0, i < 15 ? 32'(i + 1) : 32'h0);
    end
    step(0, 0, 0, 1);
    expect_st("pop_empty", 0, 1, 0, 1, 1, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 32'(i), 0);
    expect_st("five", 5, 0, 0, 1, 1, 32'h1);
    step(1, 1, 32'h99, 1);
    expect_st("flush", 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) seq[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 40; i++) seq[8 + i] = 32'h200 + 32'(i);
    for (int i = 0; i < 8; i++) step(0, 1, seq[i], 0);
    expect_st("fill8", 8, 0, 0, 0, 0, 32'h100);
    for (int j = 0; j < 40; j++) begin
      step(0, 1, seq[8 + j], 1);
      expect_st($sformatf("stream%0d", j), 8, 0, 0, 0, 0, seq[j + 1]);
    end
    idle();
    #2 rst_n = 0;
    #1 expect_st("async_rst", 0, 1, 0, 0, 0, 0);
    #3 rst_n = 1;
    @(posedge clk) #1 expect_st("post_rst", 0, 1, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/f2h_result_fifo.md
# f2h_result_fifo

Show-ahead buffer between the NPU result writer and the FPGA-to-HPS PIO read port. NPU results are pushed with a valid/ready handshake. The HPS pops one word per PIO read strobe. The head word is always presented on `rd_data`, so the PIO register captures it on the same edge that pops it. Level and sticky error flags are exported for a status PIO.

## Interface
- `WIDTH`, 32, data word width.
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous clear of contents and flags.
- `wr_valid` input 1: producer offers `wr_data`.
- `wr_data` input WIDTH: result word.
- `wr_ready` output 1: FIFO can accept; equals `!full`.
- `rd_en` input 1: pop strobe from the PIO `read_en_out`.
- `rd_data` output WIDTH: head word (show-ahead); drives the PIO `read_data_in`.
- `count` output $clog2(DEPTH)+1: occupancy, 0..DEPTH.
- `empty` output 1: count == 0.
- `full` output 1: count == DEPTH.
- `overflow` output 1: sticky; a push was attempted while full.
- `underflow` output 1: sticky; a pop was attempted while empty.

## Operation
- State: storage array, `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits each, `count` register, two sticky flags.
- Push is accepted when `wr_valid && !full`. Accepting a push writes `mem[wr_ptr]` and increments `wr_ptr`, which wraps modulo DEPTH.
- Pop is accepted when `rd_en && !empty`. Accepting a pop increments `rd_ptr`, which wraps modulo DEPTH.
- `count` update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- `rd_data` = `mem[rd_ptr]` when `!empty`, else all zeros. It is combinational from registered state only.
- Full with push and pop in the same cycle: the push is refused because `wr_ready` is 0. The pop proceeds. `overflow` is set.
- Empty with push and pop in the same cycle: the push is accepted. The pop is ignored and `underflow` is set. The new word appears on `rd_data` the next cycle.
- `wr_valid` while full: the word is dropped and `overflow` ← 1. Pointers and count are unchanged.
- `rd_en` while empty: no state change except `underflow` ← 1.
- `flush` has priority over push and pop in the same cycle. It clears:
  - both pointers
  - `count`
  - `overflow` and `underflow`
- Storage contents are not cleared by `flush`; they are unobservable while empty.
- Sticky flags are cleared only by `flush` or reset.

## Timing
- Reset values:
  - pointers 0
  - `count` 0
  - `empty` 1, `full` 0
  - `overflow` 0, `underflow` 0
  - `wr_ready` 1
  - `rd_data` 0
- Write-to-read latency: a word pushed at edge N is visible on `rd_data` after edge N (cycle N+1).
- Pop latency: on an edge with `rd_en` high and `!empty`, the PIO captures the current `rd_data`. After that edge, `rd_data` shows the next entry, or 0 if the FIFO is now empty.
- `count`, `empty`, `full`, `wr_ready` and the flags update on the same edge as the event that changes them.
- Sustained rate: one push and one pop per cycle. Back-to-back `rd_en` pops consecutive entries.
- Asserting `rst_n` low mid-stream returns everything to reset values immediately; pending data is lost.

## Structure
- Package `f2h_pkg` holds:
  - `F2H_WIDTH` = 32
  - `F2H_DEPTH` = 16
  - `f2h_word_t` (logic [F2H_WIDTH-1:0])
  - count/pointer width localparams derived with $clog2
- Sub-module `f2h_fifo_mem`: DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port. Reset is not required.
- Top level holds pointers, count, flags and the handshake logic.

## Test plan
- Reset, then idle → `empty`=1, `count`=0, `rd_data`=0, `wr_ready`=1, both flags 0.
- Push 0x11111111, 0x22222222, 0x33333333, then pulse `rd_en` three times → PIO captures the three words in order, `count` 3→0, `rd_data`=0 at the end.
- Push 16 words 0x0..0xF, then push 0xDEAD → `full`=1, `wr_ready`=0, `overflow`=1, `count`=16. Then pop 16 times → 0x0..0xF in order with no 0xDEAD.
- Fill to 8, then push and pop together for 40 cycles → `count` stays 8, data is in order across pointer wrap.
- `rd_en` while empty, with a push of 0xA5A5A5A5 in the same cycle → `underflow`=1, `count`=1, `rd_data`=0xA5A5A5A5 next cycle.
- With 5 entries and both flags set, pulse `flush` together with `wr_valid` and `rd_en` → `count`=0, `empty`=1, flags 0. Then `rst_n` low mid-stream → all outputs return to reset values asynchronously.
